// File: rtl/tone_note_detector.sv
// rtl/tone_note_detector.sv - square-wave tone period meter and C4..C5 note classifier
// Optional build macro TONE_DEGLITCH_EN adds a 4-cycle level filter after the synchronizer.
module tone_note_detector #(
   parameter int CLK_HZ      = 50000000,
   parameter int CNT_W       = 25,
   parameter int TIMEOUT_CYC = 2500000,
   parameter int TOL_SHIFT   = 6,
   parameter int STABLE_N    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tone_in,
   output logic [2:0]       note_idx,
   output logic             note_valid,
   output logic             note_change,
   output logic [CNT_W-1:0] period
);
   localparam int MC_W = $clog2(STABLE_N + 1);
   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);
   localparam logic [MC_W-1:0] MC_LOCK = MC_W'(STABLE_N);

   function automatic logic [CNT_W-1:0] note_period(input int i);
      int f;
      case (i)
         0:       f = 262;
         1:       f = 294;
         2:       f = 330;
         3:       f = 349;
         4:       f = 392;
         5:       f = 440;
         6:       f = 494;
         default: f = 523;
      endcase
      return CNT_W'(2 * ((CLK_HZ / 2) / f + 1));
   endfunction

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   logic             sync1, sync2, lvl, lvl_d, edge_q;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       hit;
   logic             cls_hit;
   logic [2:0]       cls_idx;
   state_t           state, state_n;
   logic [2:0]       cand, cand_n, idx_n;
   logic [MC_W-1:0]  mcnt, mcnt_n;
   logic             valid_n, change_n, per_ld;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= tone_in;
         sync2 <= sync1;
      end
   end

`ifdef TONE_DEGLITCH_EN
   logic [1:0] glt_cnt;
   logic       filt;

   // The filtered level only follows sync2 after 4 consecutive cycles of disagreement.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         glt_cnt <= 2'd0;
         filt    <= 1'b0;
      end else if (sync2 == filt) begin
         glt_cnt <= 2'd0;
      end else if (glt_cnt == 2'd3) begin
         glt_cnt <= 2'd0;
         filt    <= sync2;
      end else begin
         glt_cnt <= glt_cnt + 2'd1;
      end
   end

   assign lvl = filt;
`else
   assign lvl = sync2;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lvl_d  <= 1'b0;
         edge_q <= 1'b0;
         cnt    <= '0;
      end else begin
         lvl_d  <= lvl;
         edge_q <= lvl & ~lvl_d;
         if (edge_q)
            cnt <= CNT_W'(1);
         else if (cnt != TMO)
            cnt <= cnt + CNT_W'(1);
      end
   end

   // On an edge cycle cnt holds the rise-to-rise period, so classify it directly.
   for (genvar g = 0; g < 8; g++) begin : g_cls
      localparam logic [CNT_W-1:0] PER = note_period(g);
      localparam logic [CNT_W-1:0] TOL = PER >> TOL_SHIFT;
      logic [CNT_W-1:0] diff;
      assign diff   = (cnt >= PER) ? (cnt - PER) : (PER - cnt);
      assign hit[g] = (diff <= TOL);
   end

   always_comb begin
      cls_hit = |hit;
      cls_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (hit[i])
            cls_idx = 3'(i);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cand        <= 3'd0;
         mcnt        <= '0;
         note_idx    <= 3'd0;
         note_valid  <= 1'b0;
         note_change <= 1'b0;
         period      <= '0;
      end else begin
         state       <= state_n;
         cand        <= cand_n;
         mcnt        <= mcnt_n;
         note_idx    <= idx_n;
         note_valid  <= valid_n;
         note_change <= change_n;
         if (per_ld)
            period <= cnt;
      end
   end

   always_comb begin
      state_n  = state;
      cand_n   = cand;
      mcnt_n   = mcnt;
      idx_n    = note_idx;
      valid_n  = note_valid;
      change_n = 1'b0;
      per_ld   = 1'b0;
      if (edge_q) begin
         // An edge coinciding with the timeout restarts measurement rather than reporting a period.
         if (state == IDLE || cnt == TMO) begin
            state_n = ACQUIRE;
            mcnt_n  = '0;
            valid_n = 1'b0;
         end else begin
            per_ld = 1'b1;
            if (state == LOCKED) begin
               if (!(cls_hit && cls_idx == note_idx)) begin
                  state_n = ACQUIRE;
                  valid_n = 1'b0;
                  cand_n  = cls_idx;
                  mcnt_n  = cls_hit ? MC_W'(1) : '0;
               end
            end else begin
               if (!cls_hit) begin
                  mcnt_n = '0;
               end else if (cls_idx == cand) begin
                  mcnt_n = mcnt + MC_W'(1);
               end else begin
                  cand_n = cls_idx;
                  mcnt_n = MC_W'(1);
               end
               if (mcnt_n == MC_LOCK) begin
                  state_n  = LOCKED;
                  idx_n    = cand_n;
                  valid_n  = 1'b1;
                  change_n = 1'b1;
               end
            end
         end
      end else if (state != IDLE && cnt == TMO) begin
         state_n = IDLE;
         valid_n = 1'b0;
         mcnt_n  = '0;
      end
   end
endmodule
